// File: rtl/cpu_ctrl_fsm.sv
// Control FSM for the button-driven CPU: button sync, instruction latch, ALU, register file, LCD handshake.
// Optional multiplier for opcode 101 is enabled by defining CPU_MULT_EN.
module cpu_ctrl_fsm #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     botao_ligar,
    input  logic                     botao_enviar,
    input  logic [2:0]               instrucao,
    input  logic [$clog2(NREG)-1:0]  dst,
    input  logic [$clog2(NREG)-1:0]  src1,
    input  logic [$clog2(NREG)-1:0]  src2,
    input  logic [DATA_W-1:0]        imm,
    input  logic                     lcd_ready,
    output logic                     ligado,
    output logic                     busy,
    output logic [3:0]               state_o,
    output logic                     lcd_valid,
    output logic [2:0]               lcd_opcode,
    output logic [$clog2(NREG)-1:0]  lcd_reg,
    output logic [DATA_W-1:0]        lcd_value,
    output logic                     lcd_flag,
    output logic                     illegal
);

    localparam int unsigned REG_AW = $clog2(NREG);
    localparam logic [REG_AW-1:0] CntMax = REG_AW'(NREG - 1);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpAddi = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpSubi = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpClr  = 3'b110;
    localparam logic [2:0] OpShow = 3'b111;

    typedef enum logic [3:0] {
        StDesligado     = 4'd0,
        StIniciado      = 4'd1,
        StAguardando    = 4'd2,
        StGravando      = 4'd3,
        StDecodificando = 4'd4,
        StExecutando    = 4'd5,
        StEscrevendo    = 4'd6,
        StPreparandoLcd = 4'd7,
        StExibindo      = 4'd8
    } state_e;

    state_e                    state_q, state_d;
    logic [REG_AW-1:0]         cnt_q, cnt_d;
    logic [2:0]                lig_sync_q, env_sync_q;
    logic [DATA_W-1:0]         rf_q [NREG];
    logic [2:0]                op_q;
    logic [REG_AW-1:0]         dst_q, src1_q, src2_q;
    logic [DATA_W-1:0]         imm_q, res_q;
    logic                      flag_q;
    logic [2:0]                fop_q;
    logic [REG_AW-1:0]         freg_q;
    logic [DATA_W-1:0]         fval_q;
    logic                      fflag_q;

    logic                      lig_edge, env_edge;
    logic                      ir_load, alu_load, clr_we, res_we, frame_load, frame_clr;
    logic                      op_writes, op_illegal;
    logic [DATA_W-1:0]         opa, opb, alu_res;
    logic                      alu_flag;

    // Bit 0 is the first sync flop; edge pulse is s2 & ~s3
    assign lig_edge = lig_sync_q[1] & ~lig_sync_q[2];
    assign env_edge = env_sync_q[1] & ~env_sync_q[2];

    assign opa = rf_q[src1_q];
    assign opb = rf_q[src2_q];

`ifdef CPU_MULT_EN
    logic [2*DATA_W-1:0] prod;
    assign prod       = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};
    assign op_illegal = 1'b0;
    assign op_writes  = (op_q <= OpSubi) || (op_q == OpMul);
`else
    assign op_illegal = (op_q == OpMul);
    assign op_writes  = (op_q <= OpSubi);
`endif

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op_q)
            OpLoad: alu_res = imm_q;
            OpAdd:  {alu_flag, alu_res} = {1'b0, opa} + {1'b0, opb};
            OpAddi: {alu_flag, alu_res} = {1'b0, opa} + {1'b0, imm_q};
            OpSub: begin
                alu_res  = opa - opb;
                alu_flag = (opa < opb);
            end
            OpSubi: begin
                alu_res  = opa - imm_q;
                alu_flag = (opa < imm_q);
            end
`ifdef CPU_MULT_EN
            OpMul: begin
                alu_res  = prod[DATA_W-1:0];
                alu_flag = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            OpShow: alu_res = opa;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_load    = 1'b0;
        alu_load   = 1'b0;
        clr_we     = 1'b0;
        res_we     = 1'b0;
        frame_load = 1'b0;
        frame_clr  = 1'b0;
        // Power-off wins over everything and abandons the current operation
        if (state_q != StDesligado && lig_edge) begin
            state_d   = StDesligado;
            cnt_d     = '0;
            frame_clr = 1'b1;
        end else begin
            case (state_q)
                StDesligado: begin
                    if (lig_edge) begin
                        state_d = StIniciado;
                        cnt_d   = '0;
                    end
                end
                StIniciado: begin
                    clr_we = 1'b1;
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        state_d = StAguardando;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StAguardando:    if (env_edge) state_d = StGravando;
                StGravando: begin
                    ir_load = 1'b1;
                    state_d = StDecodificando;
                end
                StDecodificando: begin
                    alu_load = 1'b1;
                    state_d  = StExecutando;
                end
                StExecutando:    state_d = StEscrevendo;
                StEscrevendo: begin
                    if (op_q == OpClr) begin
                        clr_we = 1'b1;
                        if (cnt_q == CntMax) begin
                            cnt_d      = '0;
                            frame_load = 1'b1;
                            state_d    = StPreparandoLcd;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        res_we     = op_writes;
                        frame_load = 1'b1;
                        state_d    = StPreparandoLcd;
                    end
                end
                StPreparandoLcd: if (lcd_ready) state_d = StExibindo;
                StExibindo:      state_d = StAguardando;
                default:         state_d = StDesligado;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StDesligado;
            cnt_q      <= '0;
            lig_sync_q <= '0;
            env_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lig_sync_q <= {lig_sync_q[1:0], botao_ligar};
            env_sync_q <= {env_sync_q[1:0], botao_enviar};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            fop_q   <= '0;
            freg_q  <= '0;
            fval_q  <= '0;
            fflag_q <= 1'b0;
        end else begin
            if (clr_we) begin
                rf_q[cnt_q] <= '0;
            end else if (res_we) begin
                rf_q[dst_q] <= res_q;
            end
            if (ir_load) begin
                op_q   <= instrucao;
                dst_q  <= dst;
                src1_q <= src1;
                src2_q <= src2;
                imm_q  <= imm;
            end
            if (alu_load) begin
                res_q  <= alu_res;
                flag_q <= alu_flag;
            end
            if (frame_clr) begin
                fop_q   <= '0;
                freg_q  <= '0;
                fval_q  <= '0;
                fflag_q <= 1'b0;
            end else if (frame_load) begin
                fop_q   <= op_q;
                freg_q  <= (op_q == OpShow) ? src1_q : dst_q;
                fval_q  <= res_q;
                fflag_q <= flag_q;
            end
        end
    end

    assign ligado     = (state_q != StDesligado);
    assign busy       = !(state_q inside {StDesligado, StAguardando, StExibindo});
    assign state_o    = state_q;
    assign lcd_valid  = (state_q == StPreparandoLcd);
    assign lcd_opcode = fop_q;
    assign lcd_reg    = freg_q;
    assign lcd_value  = fval_q;
    assign lcd_flag   = fflag_q;
    assign illegal    = (state_q == StExecutando) && op_illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomised bench for cpu_ctrl_fsm against a behavioural model, plus directed literal checks.
module tb_cpu_ctrl_fsm;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int M  = 256;

    logic       clk = 1'b0;
    logic       rst_n, botao_ligar, botao_enviar, lcd_ready;
    logic [2:0] instrucao, dst, src1, src2;
    logic [7:0] imm;
    logic       ligado, busy, lcd_valid, lcd_flag, illegal;
    logic [3:0] state_o;
    logic [2:0] lcd_opcode, lcd_reg;
    logic [7:0] lcd_value;

    cpu_ctrl_fsm #(.DATA_W(DW), .NREG(NR)) dut (
        .clk(clk), .rst_n(rst_n), .botao_ligar(botao_ligar), .botao_enviar(botao_enviar),
        .instrucao(instrucao), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
        .lcd_ready(lcd_ready), .ligado(ligado), .busy(busy), .state_o(state_o),
        .lcd_valid(lcd_valid), .lcd_opcode(lcd_opcode), .lcd_reg(lcd_reg),
        .lcd_value(lcd_value), .lcd_flag(lcd_flag), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;
    int init_cnt, escr_cnt, ill_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: spec states 0..8, integer register file and frame
    int m_state, m_cnt, m_reg[NR];
    int m_op, m_dst, m_s1, m_res, m_flag, m_wr, m_ill;
    int m_fop, m_freg, m_fval, m_fflag;
    bit l1, l2, l3, e1, e2, e3;

    always @(posedge clk) begin
        bit lig, env;
        longint a, b, r;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_op = 0; m_dst = 0; m_s1 = 0; m_res = 0; m_flag = 0;
            m_wr = 0; m_ill = 0; m_fop = 0; m_freg = 0; m_fval = 0; m_fflag = 0;
            foreach (m_reg[i]) m_reg[i] = 0;
            {l1, l2, l3, e1, e2, e3} = '0;
        end else begin
            lig = l2 && !l3;
            env = e2 && !e3;
            l3 = l2; l2 = l1; l1 = botao_ligar;
            e3 = e2; e2 = e1; e1 = botao_enviar;
            if (m_state != 0 && lig) begin
                m_state = 0; m_cnt = 0;
                m_fop = 0; m_freg = 0; m_fval = 0; m_fflag = 0;
            end else begin
                case (m_state)
                    0: if (lig) begin m_state = 1; m_cnt = 0; end
                    1: begin
                        m_reg[m_cnt] = 0;
                        if (m_cnt == NR - 1) begin m_cnt = 0; m_state = 2; end
                        else m_cnt++;
                    end
                    2: if (env) m_state = 3;
                    3: begin
                        m_op = instrucao; m_dst = dst; m_s1 = src1;
                        a = m_reg[src1]; b = m_reg[src2];
                        m_res = 0; m_flag = 0; m_wr = 0; m_ill = 0;
                        case (m_op)
                            0: begin m_res = imm; m_wr = 1; end
                            1: begin r = a + b;   m_res = int'(r % M); m_flag = (r >= M); m_wr = 1; end
                            2: begin r = a + imm; m_res = int'(r % M); m_flag = (r >= M); m_wr = 1; end
                            3: begin m_res = int'((a - b + M) % M); m_flag = (a < b); m_wr = 1; end
                            4: begin m_res = int'((a - imm + M) % M); m_flag = (a < imm); m_wr = 1; end
`ifdef CPU_MULT_EN
                            5: begin r = a * b; m_res = int'(r % M); m_flag = (r >= M); m_wr = 1; end
`else
                            5: m_ill = 1;
`endif
                            7: m_res = int'(a);
                            default: ;
                        endcase
                        m_state = 4;
                    end
                    4: m_state = 5;
                    5: m_state = 6;
                    6: begin
                        if (m_op == 6) begin
                            m_reg[m_cnt] = 0;
                            if (m_cnt == NR - 1) begin m_cnt = 0; m_state = 7; end
                            else m_cnt++;
                        end else begin
                            if (m_wr) m_reg[m_dst] = m_res;
                            m_state = 7;
                        end
                        if (m_state == 7) begin
                            m_fop = m_op; m_freg = (m_op == 7) ? m_s1 : m_dst;
                            m_fval = m_res; m_fflag = m_flag;
                        end
                    end
                    7: if (lcd_ready) m_state = 8;
                    8: m_state = 2;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("state_o", state_o, m_state);
            chk("ligado", ligado, m_state != 0);
            chk("busy", busy, !(m_state == 0 || m_state == 2 || m_state == 8));
            chk("lcd_valid", lcd_valid, m_state == 7);
            chk("lcd_opcode", lcd_opcode, m_fop);
            chk("lcd_reg", lcd_reg, m_freg);
            chk("lcd_value", lcd_value, m_fval);
            chk("lcd_flag", lcd_flag, m_fflag);
            chk("illegal", illegal, m_state == 5 && m_ill);
            if (state_o == 4'd1) init_cnt++;
            if (state_o == 4'd6) escr_cnt++;
            if (illegal) ill_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_state(input int s, input int bound);
        int g = 0;
        while (m_state != s && g < bound) begin step(1); g++; end
        checks++;
        if (m_state != s) begin
            errors++;
            $display("FAIL wait_state: state %0d, required %0d within %0d cycles", m_state, s, bound);
        end
    endtask

    task automatic press_ligar();
        botao_ligar = 1; step(3); botao_ligar = 0; step(3);
    endtask

    task automatic set_ins(input int op, input int d, input int a, input int b, input int im);
        instrucao = 3'(op); dst = 3'(d); src1 = 3'(a); src2 = 3'(b); imm = 8'(im);
    endtask

    // Issue one instruction from AGUARDANDO and run it back to AGUARDANDO
    task automatic run_op(input int op, input int d, input int a, input int b, input int im,
                          input int dly, output int vcnt);
        int stall = 0;
        int g = 0;
        wait_state(2, 200);
        set_ins(op, d, a, b, im);
        escr_cnt = 0;
        botao_enviar = 1; step(3); botao_enviar = 0;
        vcnt = 0;
        while (m_state != 2 && g < 100) begin
            if (m_state == 7 && stall < dly) begin lcd_ready = 0; stall++; end
            else lcd_ready = 1;
            step(1);
            if (lcd_valid) vcnt++;
            g++;
        end
        lcd_ready = 1;
        checks++;
        if (m_state != 2) begin
            errors++;
            $display("FAIL run_op: op %0d stuck in state %0d", op, m_state);
        end
    endtask

    initial begin
        int v;
        rst_n = 0; botao_ligar = 0; botao_enviar = 0; lcd_ready = 1;
        set_ins(0, 0, 0, 0, 0);
        step(1);
        chk_on = 1;
        step(1);
        rst_n = 1;
        chk("rst_state", state_o, 0);
        chk("rst_ligado", ligado, 0);
        chk("rst_value", lcd_value, 0);

        init_cnt = 0;
        press_ligar();
        wait_state(2, 40);
        chk("init_len", init_cnt, 8);
        chk("on_ligado", ligado, 1);
        chk("on_busy", busy, 0);

        run_op(0, 1, 0, 0, 200, 0, v);
        run_op(0, 2, 0, 0, 100, 0, v);
        run_op(1, 3, 1, 2, 0, 0, v);
        chk("add_valid_len", v, 1);
        chk("add_reg", lcd_reg, 3);
        chk("add_value", lcd_value, 44);
        chk("add_flag", lcd_flag, 1);

        run_op(4, 4, 1, 0, 201, 5, v);
        chk("subi_valid_len", v, 6);
        chk("subi_value", lcd_value, 255);
        chk("subi_flag", lcd_flag, 1);

        ill_cnt = 0;
        run_op(5, 5, 1, 2, 0, 0, v);
`ifdef CPU_MULT_EN
        chk("mul_value", lcd_value, 32);
        chk("mul_flag", lcd_flag, 1);
        chk("mul_illegal", ill_cnt, 0);
        run_op(7, 0, 5, 0, 0, 0, v);
        chk("show_r5", lcd_value, 32);
`else
        chk("mul_value", lcd_value, 0);
        chk("mul_flag", lcd_flag, 0);
        chk("mul_illegal", ill_cnt, 1);
        run_op(7, 0, 5, 0, 0, 0, v);
        chk("show_r5", lcd_value, 0);
`endif

        run_op(7, 0, 3, 0, 0, 0, v);
        chk("show_r3_pre", lcd_value, 44);
        run_op(6, 2, 0, 0, 0, 1, v);
        chk("clr_escr_len", escr_cnt, 8);
        chk("clr_value", lcd_value, 0);
        run_op(7, 0, 3, 0, 0, 0, v);
        chk("show_r3_post", lcd_value, 0);
        chk("show_reg", lcd_reg, 3);

        // Power-off during EXECUTANDO with a coincident enviar edge
        run_op(0, 6, 0, 0, 77, 0, v);
        wait_state(2, 20);
        set_ins(1, 7, 6, 6, 0);
        botao_enviar = 1; step(2); botao_enviar = 0; step(1);
        botao_ligar = 1; botao_enviar = 1; step(3);
        chk("off_state", state_o, 0);
        chk("off_ligado", ligado, 0);
        chk("off_valid", lcd_valid, 0);
        botao_ligar = 0; botao_enviar = 0;
        step(4);
        chk("off_stays", state_o, 0);
        press_ligar();
        wait_state(2, 40);
        run_op(7, 0, 6, 0, 0, 0, v);
        chk("repower_r6", lcd_value, 0);

        for (int it = 0; it < 60; it++) begin
            if (it % 8 == 7) begin
                wait_state(2, 200);
                set_ins($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 256);
                botao_enviar = 1; step(3); botao_enviar = 0;
                lcd_ready = 1'($urandom % 2);
                step($urandom % 10);
                press_ligar();
                lcd_ready = 1;
                chk("rand_off", state_o, 0);
                press_ligar();
                wait_state(2, 60);
            end else begin
                run_op($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 8,
                       $urandom % 256, $urandom % 4, v);
            end
        end
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
